// File: rtl/bus_if_arbiter_if.sv
// ---------------------------------------------------------------------------
// Bus_if : command/response bus shared by masters and slaves.
//
// Purpose
//    Groups the handshake and payload signals of one master/slave link so
//    that blocks such as bus_if_arbiter can take whole bus ports.
//
// Encodings
//    MCmd  : 3'd0 IDLE, 3'd1 WRITE, 3'd2 READ (other codes passed through)
//    SResp : 2'd0 NULL, 2'd1 DVA, 2'd2 FAIL, 2'd3 ERR
//
// Signals (master -> slave)
//    MCmd, MAddr, MData, MDataValid, MByteEn : command and write payload
//    MRespAccept                             : master takes the response
//    MReset_n                                : active-low reset to the slave
// Signals (slave -> master)
//    SCmdAccept, SDataAccept                 : command / write data taken
//    SResp, SData                            : response code and read data
//
// Modports
//    master : the side that issues commands
//    slave  : the side that accepts commands and returns responses
// ---------------------------------------------------------------------------
interface Bus_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [2:0]          MCmd;
   logic [ADDR_W-1:0]   MAddr;
   logic [DATA_W-1:0]   MData;
   logic                MDataValid;
   logic [DATA_W/8-1:0] MByteEn;
   logic                MRespAccept;
   logic                MReset_n;

   logic                SCmdAccept;
   logic                SDataAccept;
   logic [1:0]          SResp;
   logic [DATA_W-1:0]   SData;

   modport master (
      output MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
      input  SCmdAccept, SDataAccept, SResp, SData
   );

   modport slave (
      input  MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
      output SCmdAccept, SDataAccept, SResp, SData
   );

endinterface

// File: rtl/bus_if_arbiter.sv
// ---------------------------------------------------------------------------
// bus_if_arbiter : two-master to one-slave arbiter for Bus_if.
//
// Purpose
//    Shares one slave port between two requesters. Commands are arbitrated
//    round-robin (or fixed priority to in_0 when PRIO_0 = 1) and a grant is
//    held until the slave accepts the command. The ID of every accepted
//    command is kept in a small in-flight queue so responses, which the
//    slave returns in order, are routed back to the master that issued them.
//
// Parameters
//    NUM_IN_FLIGHT : max accepted commands awaiting response (>=2, power of 2)
//    PRIO_0        : 1 = in_0 wins every conflict, 0 = round-robin
//
// Ports
//    Clk           : clock, all state updates on the rising edge
//    Reset         : synchronous active-high reset
//    in_0          : requester 0 (preferred first after reset)
//    in_1          : requester 1
//    out           : shared slave side
//    stat_grants_0 : accepted-command count for in_0 (stats build only)
//    stat_grants_1 : accepted-command count for in_1 (stats build only)
//
// Build option
//    BUS_IF_ARBITER_STATS_EN : when defined, adds the stat_grants_* ports and
//    their 32-bit wrapping counters. Core behaviour is identical either way.
// ---------------------------------------------------------------------------
module bus_if_arbiter #(
   parameter int NUM_IN_FLIGHT = 4,
   parameter bit PRIO_0        = 1'b0
) (
   input  logic        Clk,
   input  logic        Reset,
   Bus_if.slave        in_0,
   Bus_if.slave        in_1,
   Bus_if.master       out
`ifdef BUS_IF_ARBITER_STATS_EN
   ,
   output logic [31:0] stat_grants_0,
   output logic [31:0] stat_grants_1
`endif
);

   localparam int PTR_W = $clog2(NUM_IN_FLIGHT);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] CMD_IDLE  = 3'd0;
   localparam logic [1:0] RESP_NULL = 2'd0;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } arbState_t;

   arbState_t        r_state;
   arbState_t        w_nextState;
   logic             r_holdId;
   logic             w_nextHoldId;
   logic             r_rrLast;

   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             r_idMem [NUM_IN_FLIGHT];

   logic             w_req0;
   logic             w_req1;
   logic             w_owner;
   logic             w_ownerReq;
   logic             w_full;
   logic             w_empty;
   logic             w_cmdValid;
   logic             w_grantAccept;
   logic             w_push;
   logic             w_pop;
   logic             w_head;
   logic             w_headRespAccept;
   logic             w_unused;

   // The masters' own reset outputs play no part here; the slave is reset
   // from our Reset input instead.
   assign w_unused = ^{in_0.MReset_n, in_1.MReset_n};

   assign out.MReset_n = ~Reset;

   assign w_req0 = (in_0.MCmd != CMD_IDLE);
   assign w_req1 = (in_1.MCmd != CMD_IDLE);

   // Owner selection. In HOLD the held master keeps the bus no matter who
   // else asks; in ARB a lone requester wins, and a conflict goes to the
   // master that was not granted last (or always to in_0 with PRIO_0).
   always_comb begin
      w_owner = 1'b0;
      if (r_state == ST_HOLD) begin
         w_owner = r_holdId;
      end else if (w_req0 && w_req1) begin
         w_owner = PRIO_0 ? 1'b0 : ~r_rrLast;
      end else if (w_req1) begin
         w_owner = 1'b1;
      end
   end

   assign w_ownerReq = w_owner ? w_req1 : w_req0;

   // The full flag is derived from the registered count, so a pop while full
   // only opens a slot for the following cycle.
   assign w_full  = (r_count == CNT_W'(NUM_IN_FLIGHT));
   assign w_empty = (r_count == '0);

   // A command is offered to the slave only when the owner requests and the
   // in-flight queue can take its ID.
   assign w_cmdValid    = w_ownerReq && !w_full;
   assign w_grantAccept = out.SCmdAccept && !w_full;
   assign w_push        = w_cmdValid && out.SCmdAccept;

   // Command path: payload follows the owner, the command itself is gated.
   assign out.MCmd       = w_cmdValid ? (w_owner ? in_1.MCmd : in_0.MCmd) : CMD_IDLE;
   assign out.MAddr      = w_owner ? in_1.MAddr      : in_0.MAddr;
   assign out.MData      = w_owner ? in_1.MData      : in_0.MData;
   assign out.MDataValid = w_owner ? in_1.MDataValid : in_0.MDataValid;
   assign out.MByteEn    = w_owner ? in_1.MByteEn    : in_0.MByteEn;

   // Accept handshakes go back to the owner only; the other master sees 0.
   assign in_0.SCmdAccept  = ~w_owner && w_grantAccept;
   assign in_1.SCmdAccept  =  w_owner && w_grantAccept;
   assign in_0.SDataAccept = ~w_owner && out.SDataAccept;
   assign in_1.SDataAccept =  w_owner && out.SDataAccept;

   // Next-state logic. An offered but refused command pins the grant to its
   // master until the slave takes it. When the queue is full nothing is
   // offered, so the state stays frozen.
   always_comb begin
      w_nextState  = r_state;
      w_nextHoldId = r_holdId;
      case (r_state)
         ST_ARB: begin
            if (w_cmdValid && !out.SCmdAccept) begin
               w_nextState  = ST_HOLD;
               w_nextHoldId = w_owner;
            end
         end
         ST_HOLD: begin
            if (w_push) begin
               w_nextState = ST_ARB;
            end
         end
         default: begin
            w_nextState = ST_ARB;
         end
      endcase
   end

   // Arbitration state. rr_last starts at 1 so in_0 wins the first conflict,
   // and afterwards remembers whoever had the last accepted command.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= ST_ARB;
         r_holdId <= 1'b0;
         r_rrLast <= 1'b1;
      end else begin
         r_state  <= w_nextState;
         r_holdId <= w_nextHoldId;
         if (w_push) begin
            r_rrLast <= w_owner;
         end
      end
   end

   // Response routing: the master whose ID is at the head of the queue gets
   // the slave's response; the other master sees NULL and zero data.
   assign w_head           = r_idMem[r_rdPtr];
   assign w_headRespAccept = w_head ? in_1.MRespAccept : in_0.MRespAccept;

   assign in_0.SResp = (!w_empty && !w_head) ? out.SResp : RESP_NULL;
   assign in_1.SResp = (!w_empty &&  w_head) ? out.SResp : RESP_NULL;
   assign in_0.SData = (!w_empty && !w_head) ? out.SData : '0;
   assign in_1.SData = (!w_empty &&  w_head) ? out.SData : '0;

   assign out.MRespAccept = !w_empty && w_headRespAccept;

   assign w_pop = !w_empty && (out.SResp != RESP_NULL) && w_headRespAccept;

   // In-flight ID storage. Entries need no reset: they are only read when
   // the count says they are valid.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_idMem[r_wrPtr] <= w_owner;
      end
   end

   // Queue pointers and occupancy. Pointers are PTR_W bits wide so they wrap
   // modulo the (power-of-two) depth on their own. Push and pop together
   // move both pointers and leave the count unchanged.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef BUS_IF_ARBITER_STATS_EN
   logic [31:0] r_statGrants0;
   logic [31:0] r_statGrants1;

   // Per-master accepted-command counters; they wrap naturally at 2^32.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_statGrants0 <= '0;
         r_statGrants1 <= '0;
      end else if (w_push) begin
         if (w_owner) begin
            r_statGrants1 <= r_statGrants1 + 32'd1;
         end else begin
            r_statGrants0 <= r_statGrants0 + 32'd1;
         end
      end
   end

   assign stat_grants_0 = r_statGrants0;
   assign stat_grants_1 = r_statGrants1;
`endif

endmodule

// File: tb/tb_bus_if_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_if_arbiter : self-checking bench for bus_if_arbiter.
//
// Two simple master agents issue READs (addresses 0x1000+4n / 0x2000+4n)
// up to a quota; a slave agent accepts on request and answers with the
// command address as read data. A queue-based reference model is compared
// against the DUT every cycle, and directed scenarios add hand-computed
// literal expectations.
// ---------------------------------------------------------------------------
module tb_bus_if_arbiter;

   localparam int NIF = 4;

   localparam logic [2:0] CMD_IDLE  = 3'd0;
   localparam logic [2:0] CMD_READ  = 3'd2;
   localparam logic [1:0] RESP_NULL = 2'd0;
   localparam logic [1:0] RESP_DVA  = 2'd1;

   logic Clk = 1'b0;
   logic Reset;

   Bus_if bus0 ();
   Bus_if bus1 ();
   Bus_if busOut ();

`ifdef BUS_IF_ARBITER_STATS_EN
   logic [31:0] statGrants0;
   logic [31:0] statGrants1;
`endif

   bus_if_arbiter #(
      .NUM_IN_FLIGHT(NIF),
      .PRIO_0       (1'b0)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .in_0 (bus0),
      .in_1 (bus1),
      .out  (busOut)
`ifdef BUS_IF_ARBITER_STATS_EN
      ,
      .stat_grants_0(statGrants0),
      .stat_grants_1(statGrants1)
`endif
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Agent controls and bookkeeping
   int          issued0 = 0;
   int          issued1 = 0;
   int          quota0  = 0;
   int          quota1  = 0;
   bit          slaveAccept = 1'b0;
   bit          respEnable  = 1'b0;
   bit          resetReq    = 1'b1;
   logic [31:0] slavePend [$];
   logic [31:0] rx0 [$];
   logic [31:0] rx1 [$];
   int          grantLog [$];

   // Reference model state: IDs in flight, last granted master, and the
   // master a refused command is pinned to (-1 when none).
   int mQ [$];
   int mLast   = 1;
   int mLocked = -1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   function automatic int modelOwner();
      bit r0;
      bit r1;
      r0 = (bus0.MCmd != CMD_IDLE);
      r1 = (bus1.MCmd != CMD_IDLE);
      if (mLocked >= 0) return mLocked;
      if (r0 && r1)     return (mLast == 0) ? 1 : 0;
      if (r1)           return 1;
      return 0;
   endfunction

   // Per-cycle comparison against the model, then model advance with the
   // same sampled values (these are the values committed at the next edge).
   always @(negedge Clk) begin
      int         own;
      int         head;
      bit         ownReq;
      bit         full;
      bit         push;
      bit         pop;
      logic [2:0] eCmd;
      own    = modelOwner();
      ownReq = (own == 0) ? (bus0.MCmd != CMD_IDLE) : (bus1.MCmd != CMD_IDLE);
      full   = (mQ.size() == NIF);
      eCmd   = (ownReq && !full) ? ((own == 0) ? bus0.MCmd : bus1.MCmd) : CMD_IDLE;
      head   = (mQ.size() > 0) ? mQ[0] : -1;
      if (!Reset) begin
         checkOutput("model MCmd", 32'(busOut.MCmd), 32'(eCmd));
         if (eCmd != CMD_IDLE)
            checkOutput("model MAddr", busOut.MAddr, (own == 0) ? bus0.MAddr : bus1.MAddr);
         checkOutput("model SCmdAccept0", 32'(bus0.SCmdAccept),
                     32'((own == 0 && !full) ? busOut.SCmdAccept : 1'b0));
         checkOutput("model SCmdAccept1", 32'(bus1.SCmdAccept),
                     32'((own == 1 && !full) ? busOut.SCmdAccept : 1'b0));
         checkOutput("model SDataAccept0", 32'(bus0.SDataAccept),
                     32'((own == 0) ? busOut.SDataAccept : 1'b0));
         checkOutput("model SDataAccept1", 32'(bus1.SDataAccept),
                     32'((own == 1) ? busOut.SDataAccept : 1'b0));
         checkOutput("model SResp0", 32'(bus0.SResp), 32'((head == 0) ? busOut.SResp : RESP_NULL));
         checkOutput("model SResp1", 32'(bus1.SResp), 32'((head == 1) ? busOut.SResp : RESP_NULL));
         checkOutput("model SData0", bus0.SData, (head == 0) ? busOut.SData : 32'd0);
         checkOutput("model SData1", bus1.SData, (head == 1) ? busOut.SData : 32'd0);
         checkOutput("model MRespAccept", 32'(busOut.MRespAccept),
                     32'((head < 0) ? 1'b0 : ((head == 0) ? bus0.MRespAccept : bus1.MRespAccept)));
         checkOutput("model MReset_n", 32'(busOut.MReset_n), 32'd1);
      end
      if (Reset) begin
         mQ.delete();
         mLast   = 1;
         mLocked = -1;
      end else begin
         push = (eCmd != CMD_IDLE) && busOut.SCmdAccept;
         pop  = (head >= 0) && (busOut.SResp != RESP_NULL) &&
                ((head == 0) ? bus0.MRespAccept : bus1.MRespAccept);
         if (pop) void'(mQ.pop_front());
         if (push) begin
            mQ.push_back(own);
            mLast   = own;
            mLocked = -1;
         end else if (eCmd != CMD_IDLE) begin
            mLocked = own;
         end
      end
   end

   // One clock of stimulus: drive everything just after the rising edge,
   // then at the falling edge record the handshakes that will commit.
   task automatic applyStimulus();
      @(posedge Clk);
      #1;
      Reset            = resetReq;
      bus0.MCmd        = (issued0 < quota0) ? CMD_READ : CMD_IDLE;
      bus0.MAddr       = 32'h1000 + 32'(issued0 * 4);
      bus0.MData       = 32'hA000 + 32'(issued0);
      bus1.MCmd        = (issued1 < quota1) ? CMD_READ : CMD_IDLE;
      bus1.MAddr       = 32'h2000 + 32'(issued1 * 4);
      bus1.MData       = 32'hB000 + 32'(issued1);
      busOut.SCmdAccept  = slaveAccept;
      busOut.SDataAccept = slaveAccept;
      if (respEnable && slavePend.size() > 0) begin
         busOut.SResp = RESP_DVA;
         busOut.SData = slavePend[0];
      end else begin
         busOut.SResp = RESP_NULL;
         busOut.SData = 32'd0;
      end
      @(negedge Clk);
      if (Reset) begin
         slavePend.delete();
      end else begin
         if (bus0.MCmd != CMD_IDLE && bus0.SCmdAccept) begin
            issued0++;
            grantLog.push_back(0);
         end
         if (bus1.MCmd != CMD_IDLE && bus1.SCmdAccept) begin
            issued1++;
            grantLog.push_back(1);
         end
         if (busOut.SResp == RESP_DVA && busOut.MRespAccept) void'(slavePend.pop_front());
         if (busOut.MCmd != CMD_IDLE && busOut.SCmdAccept) slavePend.push_back(busOut.MAddr);
         if (bus0.SResp == RESP_DVA && bus0.MRespAccept) rx0.push_back(bus0.SData);
         if (bus1.SResp == RESP_DVA && bus1.MRespAccept) rx1.push_back(bus1.SData);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      Reset = 1'b1;
      bus0.MCmd = CMD_IDLE;  bus0.MAddr = '0; bus0.MData = '0;
      bus0.MDataValid = 1'b0; bus0.MByteEn = 4'hF;
      bus0.MRespAccept = 1'b1; bus0.MReset_n = 1'b1;
      bus1.MCmd = CMD_IDLE;  bus1.MAddr = '0; bus1.MData = '0;
      bus1.MDataValid = 1'b0; bus1.MByteEn = 4'hF;
      bus1.MRespAccept = 1'b1; bus1.MReset_n = 1'b1;
      busOut.SCmdAccept = 1'b0; busOut.SDataAccept = 1'b0;
      busOut.SResp = RESP_NULL; busOut.SData = '0;

      // Reset state
      resetReq = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("reset MReset_n", 32'(busOut.MReset_n), 32'd0);
      resetReq = 1'b0;
      applyStimulus();
      checkOutput("idle MCmd", 32'(busOut.MCmd), 32'(CMD_IDLE));
      checkOutput("idle MRespAccept", 32'(busOut.MRespAccept), 32'd0);
      checkOutput("idle SResp0", 32'(bus0.SResp), 32'(RESP_NULL));
      checkOutput("idle MReset_n", 32'(busOut.MReset_n), 32'd1);

      // Both masters stream READs, slave always accepts, 1-cycle DVA
      $display("[TB] round-robin streaming");
      slaveAccept = 1'b1;
      respEnable  = 1'b1;
      quota0 = 8;
      quota1 = 8;
      grantLog.delete();
      repeat (16) applyStimulus();
      repeat (4) applyStimulus();
      checkOutput("rr grant count", 32'(grantLog.size()), 32'd16);
      for (int i = 0; i < grantLog.size() && i < 16; i++)
         checkOutput("rr grant order", 32'(grantLog[i]), 32'(i % 2));
      checkOutput("rr rx0 count", 32'(rx0.size()), 32'd8);
      checkOutput("rr rx1 count", 32'(rx1.size()), 32'd8);
      for (int k = 0; k < rx0.size() && k < 8; k++)
         checkOutput("rr rx0 data", rx0[k], 32'h1000 + 32'(k * 4));
      for (int k = 0; k < rx1.size() && k < 8; k++)
         checkOutput("rr rx1 data", rx1[k], 32'h2000 + 32'(k * 4));
      rx0.delete();
      rx1.delete();

      // Grant hold: in_1 refused for 3 cycles while in_0 also requests
      $display("[TB] grant hold");
      slaveAccept = 1'b0;
      quota1 = issued1 + 1;
      applyStimulus();
      checkOutput("hold c0 MCmd", 32'(busOut.MCmd), 32'(CMD_READ));
      checkOutput("hold c0 MAddr", busOut.MAddr, 32'h2020);
      quota0 = issued0 + 1;
      applyStimulus();
      checkOutput("hold c1 MAddr", busOut.MAddr, 32'h2020);
      checkOutput("hold c1 SCmdAccept0", 32'(bus0.SCmdAccept), 32'd0);
      applyStimulus();
      checkOutput("hold c2 MAddr", busOut.MAddr, 32'h2020);
      slaveAccept = 1'b1;
      applyStimulus();
      checkOutput("hold c3 MAddr", busOut.MAddr, 32'h2020);
      checkOutput("hold c3 SCmdAccept1", 32'(bus1.SCmdAccept), 32'd1);
      checkOutput("hold c3 SCmdAccept0", 32'(bus0.SCmdAccept), 32'd0);
      applyStimulus();
      checkOutput("hold c4 MAddr", busOut.MAddr, 32'h1020);
      checkOutput("hold c4 SCmdAccept0", 32'(bus0.SCmdAccept), 32'd1);
      repeat (4) applyStimulus();
      checkOutput("hold rx1", (rx1.size() == 1) ? rx1[0] : 32'hDEAD, 32'h2020);
      checkOutput("hold rx0", (rx0.size() == 1) ? rx0[0] : 32'hDEAD, 32'h1020);
      rx0.delete();
      rx1.delete();

      // Queue fill with responses held off
      $display("[TB] queue full");
      respEnable = 1'b0;
      quota0 = issued0 + 6;
      for (int k = 0; k < 4; k++) begin
         applyStimulus();
         checkOutput("full fill SCmdAccept0", 32'(bus0.SCmdAccept), 32'd1);
         checkOutput("full fill MAddr", busOut.MAddr, 32'h1024 + 32'(k * 4));
      end
      repeat (2) begin
         applyStimulus();
         checkOutput("full blocked MCmd", 32'(busOut.MCmd), 32'(CMD_IDLE));
         checkOutput("full blocked SCmdAccept0", 32'(bus0.SCmdAccept), 32'd0);
      end
      respEnable = 1'b1;
      applyStimulus();
      checkOutput("full pop MCmd", 32'(busOut.MCmd), 32'(CMD_IDLE));
      checkOutput("full pop SResp0", 32'(bus0.SResp), 32'(RESP_DVA));
      checkOutput("full pop SData0", bus0.SData, 32'h1024);
      checkOutput("full pop MRespAccept", 32'(busOut.MRespAccept), 32'd1);
      respEnable = 1'b0;
      applyStimulus();
      checkOutput("full fifth MCmd", 32'(busOut.MCmd), 32'(CMD_READ));
      checkOutput("full fifth SCmdAccept0", 32'(bus0.SCmdAccept), 32'd1);
      checkOutput("full fifth MAddr", busOut.MAddr, 32'h1034);
      applyStimulus();
      checkOutput("full again MCmd", 32'(busOut.MCmd), 32'(CMD_IDLE));

      // Pop at full, then simultaneous push/pop with mixed IDs
      $display("[TB] push and pop together");
      quota0 = issued0;
      quota1 = issued1 + 1;
      respEnable = 1'b1;
      applyStimulus();
      checkOutput("pp a MCmd", 32'(busOut.MCmd), 32'(CMD_IDLE));
      checkOutput("pp a SCmdAccept1", 32'(bus1.SCmdAccept), 32'd0);
      checkOutput("pp a SData0", bus0.SData, 32'h1028);
      applyStimulus();
      checkOutput("pp b SCmdAccept1", 32'(bus1.SCmdAccept), 32'd1);
      checkOutput("pp b MAddr", busOut.MAddr, 32'h2024);
      checkOutput("pp b SResp0", 32'(bus0.SResp), 32'(RESP_DVA));
      checkOutput("pp b SResp1", 32'(bus1.SResp), 32'(RESP_NULL));
      respEnable = 1'b0;
      quota0 = issued0 + 2;
      applyStimulus();
      checkOutput("pp c SCmdAccept0", 32'(bus0.SCmdAccept), 32'd1);
      checkOutput("pp c MAddr", busOut.MAddr, 32'h1038);
      applyStimulus();
      checkOutput("pp d MCmd", 32'(busOut.MCmd), 32'(CMD_IDLE));
      quota0 = issued0;
      respEnable = 1'b1;
      repeat (8) applyStimulus();
      checkOutput("pp rx0 count", 32'(rx0.size()), 32'd6);
      for (int k = 0; k < rx0.size() && k < 6; k++)
         checkOutput("pp rx0 data", rx0[k], 32'h1024 + 32'(k * 4));
      checkOutput("pp rx1", (rx1.size() == 1) ? rx1[0] : 32'hDEAD, 32'h2024);
      rx0.delete();
      rx1.delete();

      // Reset with 3 commands outstanding
      $display("[TB] reset with outstanding commands");
      respEnable = 1'b0;
      quota0 = issued0 + 3;
      repeat (3) applyStimulus();
      resetReq = 1'b1;
      applyStimulus();
      checkOutput("rst MReset_n", 32'(busOut.MReset_n), 32'd0);
      resetReq = 1'b0;
      quota0 = issued0 + 1;
      quota1 = issued1 + 1;
      respEnable = 1'b1;
      applyStimulus();
      checkOutput("rst MRespAccept", 32'(busOut.MRespAccept), 32'd0);
      checkOutput("rst SResp0", 32'(bus0.SResp), 32'(RESP_NULL));
      checkOutput("rst SCmdAccept0", 32'(bus0.SCmdAccept), 32'd1);
      checkOutput("rst SCmdAccept1", 32'(bus1.SCmdAccept), 32'd0);
      checkOutput("rst MAddr", busOut.MAddr, 32'h1048);
      repeat (4) applyStimulus();
      checkOutput("rst rx0", (rx0.size() == 1) ? rx0[0] : 32'hDEAD, 32'h1048);
      checkOutput("rst rx1", (rx1.size() == 1) ? rx1[0] : 32'hDEAD, 32'h2028);

`ifdef BUS_IF_ARBITER_STATS_EN
      // Grant statistics: 10 in_0 and 6 in_1 accepted since the last reset
      $display("[TB] grant statistics");
      quota0 = issued0 + 9;
      quota1 = issued1 + 5;
      repeat (24) applyStimulus();
      checkOutput("stat_grants_0", statGrants0, 32'd10);
      checkOutput("stat_grants_1", statGrants1, 32'd6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
